sine_pdm_dac: RTL and testbench
===============================

// Module: sine_pdm_dac
// PURPOSE
//  First-order delta-sigma (PDM) DAC stage that consumes the sine sample
//  stream from the sine generator and drives a single-bit pin for an
//  external RC low-pass filter. Samples are accepted on a valid/ready
//  handshake, once every (osr+1) enabled clocks. Between accepts the held
//  sample is noise-shaped into a 1-bit density.
// PARAMETERS
//  DATA_W  8  sample width; unsigned offset-binary, mid-scale = 2^(DATA_W-1)
//  OSR_W   8  width of the oversample-period input osr
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       asynchronous active-low reset
//  en            in   1       stage enable; low freezes all state
//  osr           in   OSR_W   clocks per sample minus 1
//  s_data        in   DATA_W  sample from upstream sine generator
//  s_valid       in   1       s_data valid
//  s_ready       out  1       stage accepts a sample this cycle
//  underrun_clr  in   1       clears the underrun flag
//  pdm_out       out  1       registered 1-bit density output
//  sample_tick   out  1       one-cycle pulse at each sample boundary
//  underrun      out  1       sticky: boundary reached with s_valid low
// BEHAVIOUR
//  - Reset values: hold_q=2^(DATA_W-1), acc_q=0, cnt_q=0, pdm_out=0,
//    underrun=0, LFSR=16'hACE1 (dither builds only).
//  - Reset is asynchronous on assert and synchronous on release. Reset
//    mid-sample discards the held sample and the accumulator.
//  - tick = en && (cnt_q==0). sample_tick=tick and s_ready=tick; both are
//    combinational from registered state. s_ready does not depend on s_valid.
//  - Counter, on en only:
//      tick    -> cnt_q <= osr (osr is sampled here only)
//      else    -> cnt_q <= cnt_q-1
//  - Handshake:
//      tick && s_valid   -> hold_q <= s_data; the new value reaches the
//                           accumulator on the next cycle
//      tick && !s_valid  -> hold_q unchanged (last sample repeats);
//                           underrun <= 1
//  - underrun_clr clears underrun. If a set and a clear happen in the
//    same cycle, the set wins.
//  - Modulator, on en: {c, acc_q} <= acc_q + hold_q in (DATA_W+1) bits;
//    pdm_out <= c. acc_q wraps modulo 2^DATA_W.
//  - Density: with hold=h constant for 2^DATA_W clocks, pdm_out has exactly
//    h ones, because acc returns to its start value.
//  - Latency: a sample accepted at tick cycle T first affects pdm_out at
//    the clock edge ending cycle T+1.
//  - en low: cnt_q, acc_q, hold_q and LFSR hold their values. pdm_out is
//    forced to 0 at the next edge. s_ready=0, sample_tick=0. underrun_clr
//    still works.
//  - Boundaries:
//      osr=0          -> a tick every enabled cycle
//      h=0            -> pdm_out stays 0
//      h=2^DATA_W-1   -> exactly one 0 per 2^DATA_W clocks
//  - Changing osr mid-sample has no effect until the next tick.
// CONFIGURATION
//  SINE_PDM_DITHER_EN defined:
//  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) steps on each en cycle.
//  - The modulator input becomes clamp(hold_q + lfsr[0] - lfsr[1]) to
//    [0, 2^DATA_W-1]. This is zero-mean and breaks idle tones.
//  - The exact-density rule relaxes to within +/-2 ones per 2^DATA_W clocks.
//  SINE_PDM_DITHER_EN undefined:
//  - No LFSR; the modulator input is hold_q exactly.
//  - The port list is identical in both builds.
// TESTING
//  1 Reset, en=1, s_valid=0, no dither -> pdm_out 0,1,0,1...;
//    underrun=1 on the first cycle after reset.
//  2 osr=255, push 0x40 at tick -> exactly 64 ones in the 256 clocks
//    starting 2 cycles after accept; 0x00 -> 0 ones; 0xFF -> 255 ones.
//  3 osr=3, s_valid held high -> s_ready/sample_tick every 4th cycle;
//    each s_data seen at a ready cycle is loaded; others are ignored.
//  4 s_valid low at a tick -> underrun=1 and previous sample repeats;
//    underrun_clr on the same cycle as a new underrun -> flag stays 1.
//  5 en low for 10 cycles mid-sample -> pdm_out=0, cnt/acc frozen;
//    after en rises the count resumes with no extra tick.
//  6 rst_n pulsed asynchronously mid-sample -> all outputs at reset
//    values immediately; then repeat scenario 1 in both dither builds.

Source files
------------

// File: rtl/sine_pdm_dac.sv
// ============================================================================
//  Module      : sine_pdm_dac
//  Description : First-order delta-sigma (PDM) DAC stage fed by a sine sample
//                stream over valid/ready; one sample per (osr+1) enabled clocks.
//                Optional build macro SINE_PDM_DITHER_EN adds LFSR dither.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sine_pdm_dac #(
    parameter int DATA_W = 8,
    parameter int OSR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [OSR_W-1:0]  osr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              underrun_clr,
    output logic              pdm_out,
    output logic              sample_tick,
    output logic              underrun
);

    localparam logic [DATA_W-1:0] c_MID = {1'b1, {(DATA_W-1){1'b0}}};

    logic [OSR_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_acc;
    logic              r_pdm;
    logic              r_underrun;

    logic              w_tick;
    logic [DATA_W-1:0] w_mod_in;
    logic [DATA_W:0]   w_sum;

    assign w_tick      = en && (r_cnt == '0);
    assign s_ready     = w_tick;
    assign sample_tick = w_tick;
    assign pdm_out     = r_pdm;
    assign underrun    = r_underrun;

`ifdef SINE_PDM_DITHER_EN
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    logic [15:0]       r_lfsr;
    logic              w_lfsr_fb;
    logic [DATA_W+1:0] w_dsum;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Zero-mean +/-1 dither; the two extra bits catch underflow (MSB) and overflow.
    assign w_dsum = {2'b00, r_hold}
                  + {{(DATA_W+1){1'b0}}, r_lfsr[0]}
                  - {{(DATA_W+1){1'b0}}, r_lfsr[1]};

    always_comb begin
        w_mod_in = w_dsum[DATA_W-1:0];
        if (w_dsum[DATA_W+1]) begin
            w_mod_in = '0;
        end else if (w_dsum[DATA_W]) begin
            w_mod_in = '1;
        end
    end
`else
    assign w_mod_in = r_hold;
`endif

    assign w_sum = {1'b0, r_acc} + {1'b0, w_mod_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_hold     <= c_MID;
            r_acc      <= '0;
            r_pdm      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (en) begin
                if (w_tick) begin
                    r_cnt <= osr;
                    if (s_valid) begin
                        r_hold <= s_data;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                // Carry out of the accumulator is the density bit.
                {r_pdm, r_acc} <= w_sum;
            end else begin
                r_pdm <= 1'b0;
            end

            if (w_tick && !s_valid) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sine_pdm_dac.sv
// ============================================================================
//  Module      : tb_sine_pdm_dac
//  Description : Self-checking bench for sine_pdm_dac against a cycle model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sine_pdm_dac;

    localparam int DATA_W = 8;
    localparam int OSR_W  = 8;
    localparam int FULL   = 1 << DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [OSR_W-1:0]  osr;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              underrun_clr;
    logic              s_ready;
    logic              pdm_out;
    logic              sample_tick;
    logic              underrun;

    sine_pdm_dac #(.DATA_W(DATA_W), .OSR_W(OSR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .osr          (osr),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .underrun_clr (underrun_clr),
        .pdm_out      (pdm_out),
        .sample_tick  (sample_tick),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          m_hold;
    int          m_acc;
    int          m_cnt;
    int          m_pdm;
    int          m_und;
    logic [15:0] m_lfsr;
    logic        obs_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = FULL / 2;
        m_acc  = 0;
        m_cnt  = 0;
        m_pdm  = 0;
        m_und  = 0;
        m_lfsr = 16'hACE1;
    endtask

    // One clock of the reference behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit tick;
        int next_hold;
        int mi;
        tick      = en && (m_cnt == 0);
        next_hold = m_hold;
        if (en) begin
            mi = m_hold;
`ifdef SINE_PDM_DITHER_EN
            mi = m_hold + int'(m_lfsr[0]) - int'(m_lfsr[1]);
            if (mi < 0) mi = 0;
            if (mi > FULL - 1) mi = FULL - 1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            m_pdm = ((m_acc + mi) >= FULL) ? 1 : 0;
            m_acc = (m_acc + mi) % FULL;
            if (tick) begin
                m_cnt = int'(osr);
                if (s_valid) next_hold = int'(s_data);
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else begin
            m_pdm = 0;
        end
        if (tick && !s_valid) m_und = 1;
        else if (underrun_clr) m_und = 0;
        m_hold = next_hold;
    endtask

    task automatic step();
        #1;
        obs_ready = s_ready;
        check("s_ready", s_ready, (en && m_cnt == 0));
        check("sample_tick", sample_tick, (en && m_cnt == 0));
        model_edge();
        @(posedge clk);
        #1;
        check("pdm_out", pdm_out, m_pdm);
        check("underrun", underrun, m_und);
    endtask

    task automatic scenario1(input string tag);
        osr     = '0;
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
`ifndef SINE_PDM_DITHER_EN
            check({tag, "_pattern"}, pdm_out, i % 2);
`endif
            if (i == 0) check({tag, "_underrun_first"}, underrun, 1);
        end
    endtask

    // Counts ones over the 256 clocks during which h is the held sample; the
    // final cycle is the next tick, where d_next is accepted with osr_next.
    task automatic window(input int h, input int osr_next, input int d_next, input string tag);
        int ones;
        int diff;
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            s_valid = (i == 255);
            s_data  = (i == 255) ? DATA_W'(d_next) : DATA_W'($urandom);
            if (i == 100) osr = OSR_W'($urandom);
            if (i == 255) osr = OSR_W'(osr_next);
            step();
            ones += int'(pdm_out);
        end
        diff = ones - h;
`ifdef SINE_PDM_DITHER_EN
        check(tag, (diff >= -2 && diff <= 2), 1);
        if (diff < -2 || diff > 2) $display("  %s ones=%0d h=%0d", tag, ones, h);
`else
        check(tag, ones, h);
`endif
    endtask

    initial begin
        int r;
        int saved;
        int n;
        bit got;

        rst_n        = 1'b0;
        en           = 1'b0;
        osr          = '0;
        s_data       = '0;
        s_valid      = 1'b0;
        underrun_clr = 1'b0;
        model_reset();

        #2;
        check("rst_pdm", pdm_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready_en_low", s_ready, 0);
        check("rst_tick_en_low", sample_tick, 0);
        #1 en = 1'b1;
        #5 rst_n = 1'b1;

        scenario1("sc1");

        // Density windows at osr=255 with a mid-sample osr disturbance.
        osr     = 8'd255;
        s_valid = 1'b1;
        s_data  = 8'h40;
        step();
        r = int'($urandom_range(1, 254));
        window(8'h40, 255, 8'h00, "dens_40");
        window(8'h00, 255, 8'hFF, "dens_00");
        window(8'hFF, 255, r, "dens_FF");
        window(r, 3, int'($urandom_range(0, 255)), "dens_rand");

        // osr=3 with valid held high: ready every 4th cycle.
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = DATA_W'($urandom);
            step();
            check("sc3_ready_phase", obs_ready, (i % 4 == 3));
        end

        // Underrun set/clear priority.
        underrun_clr = 1'b1;
        for (int k = 0; k < 300 && m_cnt != 0; k++) step();
        check("sc4_cleared", underrun, 0);
        s_valid = 1'b0;
        step();
        check("sc4_set_wins", underrun, 1);
        s_valid = 1'b1;
        step();
        check("sc4_clear_later", underrun, 0);
        underrun_clr = 1'b0;
        s_valid      = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("sc4_underrun_repeat", underrun, 1);

        // Enable low mid-sample.
        osr     = 8'd7;
        s_valid = 1'b1;
        for (int k = 0; k < 300 && m_cnt != 0; k++) begin
            s_data = DATA_W'($urandom);
            step();
        end
        s_data = DATA_W'($urandom_range(100, 200));
        step();
        for (int i = 0; i < 3; i++) step();
        saved        = m_cnt;
        en           = 1'b0;
        underrun_clr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sc5_pdm_low", pdm_out, 0);
            check("sc5_ready_low", obs_ready, 0);
        end
        check("sc5_clr_while_off", underrun, 0);
        underrun_clr = 1'b0;
        en           = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (obs_ready) got = 1'b1;
            else n++;
        end
        check("sc5_tick_seen", got, 1);
        check("sc5_resume_count", n, 4);
        check("sc5_resume_model", n, saved);

        // Asynchronous reset mid-sample.
        for (int k = 0; k < 300 && m_cnt != 0; k++) step();
        s_valid = 1'b0;
        step();
        step();
        step();
        check("sc6_pre_reset_und", underrun, 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("sc6_async_pdm", pdm_out, 0);
        check("sc6_async_und", underrun, 0);
        check("sc6_async_ready", s_ready, 1);
        check("sc6_async_tick", sample_tick, 1);
        #2 rst_n = 1'b1;
        scenario1("sc6");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            en           = ($urandom % 8) != 0;
            s_valid      = ($urandom % 4) != 0;
            s_data       = DATA_W'($urandom);
            osr          = OSR_W'($urandom % 6);
            underrun_clr = ($urandom % 5) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
